ps2_frame_receiver: RTL and testbench
=====================================

// Module: ps2_frame_receiver
// PURPOSE
//  Parametrised PS/2 device-to-host frame receiver with start/parity/stop checking, inter-edge timeout
//  and an output FIFO. Sits between the PS/2 clock-edge detector/synchroniser and the scancode decoder.
//  Replaces the fixed 8-bit strobe-only receiver: ready/valid output, error reporting, buffering.
// PARAMETERS
//  DATA_BITS      8      payload bits per frame, LSB first (5..9)
//  PARITY_MODE    1      0 = no parity bit, 1 = odd, 2 = even
//  TIMEOUT_CYCLES 20000  max clk cycles between ps2_clk_posedge pulses inside a frame (>=2)
//  FIFO_DEPTH     4      output FIFO entries, power of two (>=2)
// PORTS
//  clk            in   1                       system clock
//  rst            in   1                       synchronous, active-high reset
//  enable         in   1                       allow new frame start
//  ps2_clk_posedge in  1                       1-cycle pulse, synchronised PS/2 clock rising edge
//  ps2_data       in   1                       synchronised PS/2 data line
//  rx_ready       in   1                       consumer accepts head entry
//  rx_valid       out  1                       FIFO not empty
//  rx_data        out  DATA_BITS               head entry payload
//  rx_parity_err  out  1                       head entry had parity mismatch (0 when PARITY_MODE=0)
//  frame_err_strb out  1                       1-cycle pulse: frame aborted
//  frame_err_code out  2                       01 = stop bit 0, 10 = timeout; held until next abort
//  overflow_strb  out  1                       1-cycle pulse: good frame dropped, FIFO full
//  fifo_count     out  $clog2(FIFO_DEPTH)+1    entries stored
//  busy           out  1                       FSM not in IDLE
// BEHAVIOUR
//  Reset: FSM IDLE, FIFO empty; all outputs 0 (rx_data, fifo_count, frame_err_code = 0).
//  FSM: IDLE -> DATA on ps2_clk_posedge && ps2_data==0 && enable (start bit).
//   DATA: shift ps2_data into MSB on each edge; after DATA_BITS edges -> PARITY (PARITY_MODE!=0) or STOP.
//   PARITY: on edge, capture bit, compute err = (^payload ^ bit) != (PARITY_MODE==1) -> STOP.
//   STOP: on edge -> IDLE; ps2_data==1: push {parity_err,payload}; ps2_data==0: discard, code 01.
//  enable only gates IDLE->DATA; deasserting mid-frame does not abort the frame.
//  Edge with ps2_data==1 in IDLE is ignored (no start).
//  Timeout counter: cleared on every edge and in IDLE; in DATA/PARITY/STOP reaching TIMEOUT_CYCLES
//   forces IDLE next cycle, frame_err_strb=1, code 10, partial payload discarded. Edge and timeout in
//   same cycle: edge wins.
//  Strobes registered: frame_err_strb/overflow_strb assert the cycle after the STOP-edge/timeout cycle.
//  Push latency: entry visible (rx_valid=1, fifo_count+1) the cycle after the stop-bit edge.
//  FIFO first-word-fall-through: rx_data/rx_parity_err show head combinationally from storage;
//   pop when rx_valid && rx_ready; rx_ready while empty has no effect.
//  Full + push + pop same cycle: both happen, count unchanged, no overflow.
//  Full + push without pop: frame dropped, overflow_strb pulse, stored entries untouched.
//  Pointers wrap modulo FIFO_DEPTH; fifo_count range 0..FIFO_DEPTH.
//  rst mid-frame or with FIFO non-empty: abort frame, flush FIFO, no strobes the following cycle.
// TESTING
//  Defaults, frame 0x1C odd parity=0, stop=1 -> rx_valid, rx_data=0x1C, rx_parity_err=0, fifo_count=1.
//  Same frame parity=1 -> entry 0x1C stored with rx_parity_err=1; PARITY_MODE=0 build: 10-bit frame ok.
//  Stop bit 0 -> no push, frame_err_strb 1 cycle, frame_err_code=01, next good frame 0xF0 accepted.
//  Stall after 4 data bits for 20000 cycles -> timeout pulse, code 10, busy=0, FIFO unchanged.
//  rx_ready=0, send 5 frames 0x01..0x05 -> fifo_count=4, one overflow_strb; drain yields 0x01..0x04.
//  FIFO full, pop coincident with stop edge of 0x06 -> no overflow, count stays 4, order preserved.

Source files
------------

// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host frame receiver: start/parity/stop checking, inter-edge
// timeout, error/overflow strobes and a first-word-fall-through output FIFO.
module ps2_frame_receiver #(
    parameter int DATA_BITS      = 8,
    parameter int PARITY_MODE    = 1,
    parameter int TIMEOUT_CYCLES = 20000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          ps2_clk_posedge,
    input  logic                          ps2_data,
    input  logic                          rx_ready,
    output logic                          rx_valid,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_parity_err,
    output logic                          frame_err_strb,
    output logic [1:0]                    frame_err_code,
    output logic                          overflow_strb,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DATA   = 2'd1;
    localparam logic [1:0] PARITY = 2'd2;
    localparam logic [1:0] STOP   = 2'd3;

    localparam logic [1:0] ERR_STOP    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(DATA_BITS - 1);
    localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
    localparam logic             ODD_MODE   = (PARITY_MODE == 1);

    typedef struct packed {
        logic                 parity_err;
        logic [DATA_BITS-1:0] data;
    } entry_t;

    logic [1:0]           state;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 parity_err;
    logic [TMR_W-1:0]     timer;

    entry_t               mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    entry_t               head;

    logic in_frame;
    logic start_hit;
    logic timeout_hit;
    logic stop_edge;
    logic push;
    logic stop_err;
    logic pop;
    logic full;
    logic push_ok;
    logic overflow;
    logic parity_calc;

    assign in_frame    = (state != IDLE);
    assign start_hit   = (state == IDLE) && ps2_clk_posedge && !ps2_data && enable;
    // A clock edge in the same cycle as the limit keeps the frame alive.
    assign timeout_hit = in_frame && !ps2_clk_posedge && (timer == TMR_LAST);
    assign stop_edge   = (state == STOP) && ps2_clk_posedge;
    assign push        = stop_edge && ps2_data;
    assign stop_err    = stop_edge && !ps2_data;
    assign parity_calc = ((^shift) ^ ps2_data) != ODD_MODE;

    assign pop      = rx_valid && rx_ready;
    assign full     = (count == FULL_COUNT);
    assign push_ok  = push && (!full || pop);
    assign overflow = push && full && !pop;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            parity_err <= 1'b0;
            timer      <= '0;
        end else begin
            if (state == IDLE || ps2_clk_posedge) begin
                timer <= '0;
            end else begin
                timer <= timer + TMR_W'(1);
            end

            case (state)
                IDLE: begin
                    if (start_hit) begin
                        state      <= DATA;
                        bit_cnt    <= '0;
                        parity_err <= 1'b0;
                    end
                end
                DATA: begin
                    if (timeout_hit) begin
                        state <= IDLE;
                    end else if (ps2_clk_posedge) begin
                        // LSB arrives first, so shifting in at the MSB leaves it at bit 0.
                        shift <= {ps2_data, shift[DATA_BITS-1:1]};
                        if (bit_cnt == LAST_BIT) begin
                            state <= (PARITY_MODE != 0) ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end
                end
                PARITY: begin
                    if (timeout_hit) begin
                        state <= IDLE;
                    end else if (ps2_clk_posedge) begin
                        parity_err <= parity_calc;
                        state      <= STOP;
                    end
                end
                STOP: begin
                    if (timeout_hit || ps2_clk_posedge) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err_strb <= 1'b0;
            overflow_strb  <= 1'b0;
            frame_err_code <= 2'b00;
        end else begin
            frame_err_strb <= stop_err || timeout_hit;
            overflow_strb  <= overflow;
            if (stop_err) begin
                frame_err_code <= ERR_STOP;
            end else if (timeout_hit) begin
                frame_err_code <= ERR_TIMEOUT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; the read side is gated by
    // rx_valid, so stale entries are never observable after a flush.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= '{parity_err: parity_err, data: shift};
        end
    end

    assign head          = mem[rd_ptr];
    assign rx_valid      = (count != '0);
    assign rx_data       = rx_valid ? head.data : '0;
    assign rx_parity_err = rx_valid && head.parity_err;
    assign fifo_count    = count;
    assign busy          = in_frame;

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Self-checking bench for ps2_frame_receiver: directed steps plus random frames
// scored against a queue-based model of the frame/FIFO rules.
module tb_ps2_frame_receiver;

    localparam int T     = 20000;
    localparam int DEPTH = 4;
    localparam int GAP   = 3;

    logic       clk = 1'b0;
    logic       rst, enable, ps2_clk_posedge, ps2_data, rx_ready;
    logic       rx_valid, rx_parity_err, frame_err_strb, overflow_strb, busy;
    logic [7:0] rx_data;
    logic [1:0] frame_err_code;
    logic [2:0] fifo_count;

    logic       p0_edge, p0_data, p0_ready;
    logic       p0_valid, p0_perr, p0_ferr, p0_ovf, p0_busy;
    logic [7:0] p0_rx_data;
    logic [1:0] p0_code;
    logic [2:0] p0_count;

    int checks = 0;
    int errors = 0;

    logic [8:0] q[$];
    logic       exp_ferr, exp_ovf;
    logic [1:0] exp_code;

    always #5 clk = ~clk;

    ps2_frame_receiver dut (
        .clk(clk), .rst(rst), .enable(enable),
        .ps2_clk_posedge(ps2_clk_posedge), .ps2_data(ps2_data), .rx_ready(rx_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_parity_err(rx_parity_err),
        .frame_err_strb(frame_err_strb), .frame_err_code(frame_err_code),
        .overflow_strb(overflow_strb), .fifo_count(fifo_count), .busy(busy)
    );

    ps2_frame_receiver #(.PARITY_MODE(0)) dut_np (
        .clk(clk), .rst(rst), .enable(enable),
        .ps2_clk_posedge(p0_edge), .ps2_data(p0_data), .rx_ready(p0_ready),
        .rx_valid(p0_valid), .rx_data(p0_rx_data), .rx_parity_err(p0_perr),
        .frame_err_strb(p0_ferr), .frame_err_code(p0_code),
        .overflow_strb(p0_ovf), .fifo_count(p0_count), .busy(p0_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic edge_bit(input logic d, input int gap);
        ps2_data        = d;
        ps2_clk_posedge = 1'b1;
        @(negedge clk);
        ps2_clk_posedge = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic edge_bit0(input logic d, input int gap);
        p0_data = d;
        p0_edge = 1'b1;
        @(negedge clk);
        p0_edge = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic check_head(input string tag);
        check({tag, "_count"}, 32'(fifo_count), 32'(q.size()));
        check({tag, "_valid"}, 32'(rx_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            check({tag, "_data"}, 32'(rx_data), 32'(q[0][7:0]));
            check({tag, "_perr"}, 32'(rx_parity_err), 32'(q[0][8]));
        end
    endtask

    // Sends one odd-parity frame; stop edge is the last edge, returns on the
    // negedge right after it so the registered strobes are visible.
    task automatic do_frame(input string tag, input logic [7:0] d, input logic pflip,
                            input logic stop, input logic pop_at_stop, input logic drop_en);
        logic pbit;
        logic popped;
        pbit   = ~(^d) ^ pflip;
        popped = pop_at_stop && (q.size() != 0);
        if (popped) check_head({tag, "_prepop"});
        edge_bit(1'b0, GAP);
        if (drop_en) enable = 1'b0;
        for (int i = 0; i < 8; i++) edge_bit(d[i], GAP);
        edge_bit(pbit, GAP);
        rx_ready = pop_at_stop;
        edge_bit(stop, 0);
        rx_ready = 1'b0;
        enable   = 1'b1;

        exp_ferr = 1'b0;
        exp_ovf  = 1'b0;
        if (popped) void'(q.pop_front());
        if (!stop) begin
            exp_ferr = 1'b1;
            exp_code = 2'b01;
        end else if (q.size() < DEPTH) begin
            q.push_back({($countones({d, pbit}) % 2) == 0, d});
        end else begin
            exp_ovf = 1'b1;
        end

        check({tag, "_ferr"}, 32'(frame_err_strb), 32'(exp_ferr));
        check({tag, "_ovf"}, 32'(overflow_strb), 32'(exp_ovf));
        check({tag, "_code"}, 32'(frame_err_code), 32'(exp_code));
        check({tag, "_busy"}, 32'(busy), 32'(0));
        check_head(tag);
        @(negedge clk);
        check({tag, "_ferr_pulse"}, 32'(frame_err_strb), 32'(0));
        check({tag, "_ovf_pulse"}, 32'(overflow_strb), 32'(0));
    endtask

    task automatic pop_one(input string tag);
        check_head(tag);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        void'(q.pop_front());
        check({tag, "_after"}, 32'(fifo_count), 32'(q.size()));
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog observed running expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic [7:0] d;
        rst = 1'b1; enable = 1'b1; ps2_clk_posedge = 1'b0; ps2_data = 1'b1; rx_ready = 1'b0;
        p0_edge = 1'b0; p0_data = 1'b1; p0_ready = 1'b0;
        exp_code = 2'b00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_valid", 32'(rx_valid), 32'(0));
        check("rst_data", 32'(rx_data), 32'(0));
        check("rst_count", 32'(fifo_count), 32'(0));
        check("rst_code", 32'(frame_err_code), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_strobes", 32'({frame_err_strb, overflow_strb, rx_parity_err}), 32'(0));

        do_frame("f1c", 8'h1C, 1'b0, 1'b1, 1'b0, 1'b0);
        pop_one("pop1c");
        do_frame("f1c_perr", 8'h1C, 1'b1, 1'b1, 1'b0, 1'b0);
        pop_one("pop1c_perr");
        do_frame("stop0", 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
        do_frame("ff0", 8'hF0, 1'b0, 1'b1, 1'b0, 1'b0);

        enable = 1'b0;
        edge_bit(1'b0, 2);
        check("en_gate_busy", 32'(busy), 32'(0));
        enable = 1'b1;
        edge_bit(1'b1, 2);
        check("idle_high_busy", 32'(busy), 32'(0));

        edge_bit(1'b0, GAP);
        for (int i = 0; i < 3; i++) edge_bit(1'b1, GAP);
        edge_bit(1'b0, 0);
        check("to_busy", 32'(busy), 32'(1));
        n = 1;
        while (!frame_err_strb && n < T + 10) begin
            @(negedge clk);
            n++;
        end
        check("to_seen", 32'(frame_err_strb), 32'(1));
        check("to_latency", 32'(n >= T - 2 && n <= T + 2), 32'(1));
        exp_code = 2'b10;
        check("to_code", 32'(frame_err_code), 32'(exp_code));
        check("to_busy_after", 32'(busy), 32'(0));
        check_head("to_fifo");
        @(negedge clk);
        check("to_pulse", 32'(frame_err_strb), 32'(0));
        pop_one("pop_f0");

        for (int i = 1; i <= 5; i++) do_frame("ovf", 8'(i), 1'b0, 1'b1, 1'b0, 1'b0);
        check("full_count", 32'(fifo_count), 32'(DEPTH));
        do_frame("full_pop_push", 8'h06, 1'b0, 1'b1, 1'b1, 1'b0);
        while (q.size() != 0) pop_one("drain_ovf");

        for (int k = 0; k < 24; k++) begin
            d = 8'($urandom);
            do_frame("rnd", d, $urandom_range(0, 3) == 0, $urandom_range(0, 7) != 0,
                     1'($urandom_range(0, 1)), 1'b0);
            if ($urandom_range(0, 2) == 0 && q.size() != 0) pop_one("rnd_pop");
        end
        while (q.size() != 0) pop_one("drain_rnd");

        do_frame("en_drop", 8'hA7, 1'b0, 1'b1, 1'b0, 1'b1);
        pop_one("pop_en_drop");

        d = 8'($urandom);
        edge_bit0(1'b0, GAP);
        for (int i = 0; i < 8; i++) edge_bit0(d[i], GAP);
        edge_bit0(1'b1, 0);
        check("np_valid", 32'(p0_valid), 32'(1));
        check("np_data", 32'(p0_rx_data), 32'(d));
        check("np_perr", 32'(p0_perr), 32'(0));
        check("np_count", 32'(p0_count), 32'(1));
        check("np_ferr", 32'(p0_ferr), 32'(0));

        do_frame("pre_rst_a", 8'h11, 1'b0, 1'b1, 1'b0, 1'b0);
        do_frame("pre_rst_b", 8'h22, 1'b0, 1'b1, 1'b0, 1'b0);
        edge_bit(1'b0, GAP);
        edge_bit(1'b1, GAP);
        check("mid_busy", 32'(busy), 32'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        exp_code = 2'b00;
        check("mrst_count", 32'(fifo_count), 32'(0));
        check("mrst_valid", 32'(rx_valid), 32'(0));
        check("mrst_busy", 32'(busy), 32'(0));
        check("mrst_code", 32'(frame_err_code), 32'(exp_code));
        @(negedge clk);
        check("mrst_strobes", 32'({frame_err_strb, overflow_strb}), 32'(0));
        check("mrst_data", 32'(rx_data), 32'(0));
        check("mrst_np_count", 32'(p0_count), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
